// File: rtl/conso_dyn_stim_seq.sv
// Load-capacitance sweep sequencer for dynamic consumption measurement.
// For each load code from capa_first to capa_last (step capa_step) it waits a
// settling time, opens a measurement window delimited by start_tick/stop_tick
// while toggling stim_out, collects the energy result (or times out), and
// offers {code, energy, timeout} on a valid/ready result port.
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   go                   start a sweep (IDLE only)
//   abort                end the sweep (any non-IDLE state)
//   capa_first/last/step sweep bounds and increment, latched on go
//   capa_charge_code     current load code to the measurement block
//   stim_out             toggling stimulus during the measurement window
//   start_tick/stop_tick one-cycle window delimiters
//   energy_in/valid      result from the measurement block
//   result_*             result handshake and payload
//   busy                 sweep in progress
//   fin_test             one-cycle end-of-sweep pulse
module conso_dyn_stim_seq #(
  parameter int unsigned CAPA_W         = 8,
  parameter int unsigned ENERGY_W       = 32,
  parameter int unsigned SETTLE_CYCLES  = 4,
  parameter int unsigned MEAS_CYCLES    = 16,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                go,
  input  logic                abort,
  input  logic [CAPA_W-1:0]   capa_first,
  input  logic [CAPA_W-1:0]   capa_last,
  input  logic [CAPA_W-1:0]   capa_step,
  output logic [CAPA_W-1:0]   capa_charge_code,
  output logic                stim_out,
  output logic                start_tick,
  output logic                stop_tick,
  input  logic [ENERGY_W-1:0] energy_in,
  input  logic                energy_valid,
  output logic                result_valid,
  input  logic                result_ready,
  output logic [CAPA_W-1:0]   result_capa,
  output logic [ENERGY_W-1:0] result_energy,
  output logic                result_timeout,
  output logic                busy,
  output logic                fin_test
);

  localparam int unsigned CNT_MAX_A = (SETTLE_CYCLES > MEAS_CYCLES) ? SETTLE_CYCLES : MEAS_CYCLES;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] MEAS_LAST   = CNT_W'(MEAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST     = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    MEASURE  = 3'd2,
    WAIT_RES = 3'd3,
    REPORT   = 3'd4,
    NEXT     = 3'd5,
    DONE     = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CAPA_W-1:0]   code_q, code_d;
  logic [CAPA_W-1:0]   last_q, last_d;
  logic [CAPA_W-1:0]   step_q, step_d;
  logic [CAPA_W-1:0]   res_capa_q, res_capa_d;
  logic [ENERGY_W-1:0] res_energy_q, res_energy_d;
  logic                res_to_q, res_to_d;
  logic                start_q, start_d;
  logic                stop_q, stop_d;
  logic                stim_q, stim_d;
  logic                valid_q, valid_d;
  logic                fin_q, fin_d;
  logic                busy_q, busy_d;
  logic [CAPA_W:0]     next_sum;

  // Next code with a carry bit so a wrap past the code range ends the sweep.
  assign next_sum = {1'b0, code_q} + {1'b0, step_q};

  // Next-state, datapath and output decode; outputs are registered from the next state.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    code_d       = code_q;
    last_d       = last_q;
    step_d       = step_q;
    res_capa_d   = res_capa_q;
    res_energy_d = res_energy_q;
    res_to_d     = res_to_q;

    if (abort && (state_q != IDLE) && (state_q != DONE)) begin
      state_d = DONE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (go) begin
            code_d  = capa_first;
            last_d  = capa_last;
            step_d  = (capa_step == '0) ? CAPA_W'(1) : capa_step;
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        SETTLE: begin
          if (cnt_q == SETTLE_LAST) begin
            cnt_d   = '0;
            state_d = MEASURE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        MEASURE: begin
          // The stop_tick cycle counts as the first cycle of the result timeout.
          if (cnt_q == MEAS_LAST) begin
            cnt_d   = CNT_ONE;
            state_d = WAIT_RES;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        WAIT_RES: begin
          if (energy_valid) begin
            res_capa_d   = code_q;
            res_energy_d = energy_in;
            res_to_d     = 1'b0;
            state_d      = REPORT;
          end else if (cnt_q >= TO_LAST) begin
            res_capa_d   = code_q;
            res_energy_d = '0;
            res_to_d     = 1'b1;
            state_d      = REPORT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        REPORT: begin
          if (result_ready) begin
            state_d = NEXT;
          end
        end
        NEXT: begin
          if (next_sum[CAPA_W] || (next_sum > {1'b0, last_q})) begin
            state_d = DONE;
          end else begin
            code_d  = next_sum[CAPA_W-1:0];
            cnt_d   = '0;
            state_d = SETTLE;
          end
        end
        DONE: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d  = (state_d != IDLE);
    start_d = (state_d == SETTLE) && (cnt_d == SETTLE_LAST);
    stop_d  = (state_d == MEASURE) && (cnt_d == MEAS_LAST);
    stim_d  = (state_d == MEASURE) && cnt_d[0];
    valid_d = (state_d == REPORT);
    fin_d   = (state_d == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      code_q       <= '0;
      last_q       <= '0;
      step_q       <= '0;
      res_capa_q   <= '0;
      res_energy_q <= '0;
      res_to_q     <= 1'b0;
      start_q      <= 1'b0;
      stop_q       <= 1'b0;
      stim_q       <= 1'b0;
      valid_q      <= 1'b0;
      fin_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      code_q       <= code_d;
      last_q       <= last_d;
      step_q       <= step_d;
      res_capa_q   <= res_capa_d;
      res_energy_q <= res_energy_d;
      res_to_q     <= res_to_d;
      start_q      <= start_d;
      stop_q       <= stop_d;
      stim_q       <= stim_d;
      valid_q      <= valid_d;
      fin_q        <= fin_d;
      busy_q       <= busy_d;
    end
  end

  assign capa_charge_code = code_q;
  assign stim_out         = stim_q;
  assign start_tick       = start_q;
  // An abort closes an open window in the very cycle it is seen.
  assign stop_tick        = stop_q | (abort & (state_q == MEASURE));
  assign result_valid     = valid_q;
  assign result_capa      = res_capa_q;
  assign result_energy    = res_energy_q;
  assign result_timeout   = res_to_q;
  assign busy             = busy_q;
  assign fin_test         = fin_q;

endmodule

// File: tb/tb_conso_dyn_stim_seq.sv
// Self-checking bench for conso_dyn_stim_seq: timestamp-based sweep model,
// per-cycle output compare, directed scenarios plus randomized sweeps.
module tb_conso_dyn_stim_seq;

  localparam int S = 4;
  localparam int M = 16;
  localparam int T = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        go = 1'b0;
  logic        abort = 1'b0;
  logic [7:0]  capa_first = '0;
  logic [7:0]  capa_last = '0;
  logic [7:0]  capa_step = '0;
  logic [7:0]  capa_charge_code;
  logic        stim_out, start_tick, stop_tick;
  logic [31:0] energy_in = '0;
  logic        energy_valid = 1'b0;
  logic        result_valid;
  logic        result_ready = 1'b0;
  logic [7:0]  result_capa;
  logic [31:0] result_energy;
  logic        result_timeout, busy, fin_test;

  conso_dyn_stim_seq dut (
    .clk(clk), .rst_n(rst_n), .go(go), .abort(abort),
    .capa_first(capa_first), .capa_last(capa_last), .capa_step(capa_step),
    .capa_charge_code(capa_charge_code), .stim_out(stim_out),
    .start_tick(start_tick), .stop_tick(stop_tick),
    .energy_in(energy_in), .energy_valid(energy_valid),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_capa(result_capa), .result_energy(result_energy),
    .result_timeout(result_timeout), .busy(busy), .fin_test(fin_test)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  // Background driver controls (written by the main process only).
  int rdy_mode = 0;      // 0 ready=1, 1 ready=0, 2 random
  int resp_dly = 3;      // cycles from stop_tick to energy_valid, 0 = never
  bit resp_rand = 1'b0;
  bit noise_en = 1'b0;
  bit abort_req = 1'b0;
  bit abort_rnd = 1'b0;

  // Model: a sweep is a series of points, each described by timestamps.
  bit          m_active = 1'b0;
  int          m_code = 0, m_last = 0, m_step = 1;
  int          t0 = 0, stop_c = 0, res_c = -1, xfer_c = -1, done_c = -1;
  int          m_res_capa = 0;
  bit          m_to = 1'b0;
  logic [31:0] m_energy = '0;

  // Observation logs for the directed literal checks.
  int          start_cyc[$], stop_cyc[$], vrise[$], xfer_capa[$], xfer_to[$];
  logic [31:0] xfer_en[$];
  int          n_fin = 0, n_stim_hi = 0;
  bit          prev_valid = 1'b0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, got, exp);
    end
  endtask

  task automatic new_point(input int s);
    t0     = s;
    stop_c = s + S + M - 1;
    res_c  = -1;
    xfer_c = -1;
  endtask

  // Model update on each clock edge from the inputs of the cycle just ended.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_active = 1'b0;
      m_code   = 0;
      done_c   = -1;
    end else begin
      if (!m_active) begin
        if (go) begin
          m_active = 1'b1;
          m_code   = int'(capa_first);
          m_last   = int'(capa_last);
          m_step   = (capa_step == 8'd0) ? 1 : int'(capa_step);
          done_c   = -1;
          new_point(cyc + 1);
        end
      end else if (cyc == done_c) begin
        m_active = 1'b0;
      end else if (abort) begin
        done_c = cyc + 1;
      end else if (xfer_c >= 0) begin
        if (m_code + m_step > m_last || m_code + m_step > 255) done_c = cyc + 1;
        else begin
          m_code = m_code + m_step;
          new_point(cyc + 1);
        end
      end else if (res_c >= 0) begin
        if (result_ready) xfer_c = cyc;
      end else if (cyc > stop_c) begin
        if (energy_valid) begin
          res_c = cyc + 1; m_energy = energy_in; m_to = 1'b0; m_res_capa = m_code;
        end else if (cyc == stop_c + T - 1) begin
          res_c = cyc + 1; m_energy = '0; m_to = 1'b1; m_res_capa = m_code;
        end
      end
      cyc++;
    end
  end

  // Per-cycle compare of every output against the model, plus event logging.
  initial forever begin
    bit live, in_meas;
    bit e_start, e_stop, e_stim, e_valid, e_fin;
    @(negedge clk);
    if (rst_n) begin
      live    = m_active && done_c < 0;
      e_fin   = m_active && cyc == done_c;
      e_start = live && cyc == t0 + S - 1;
      in_meas = live && cyc >= t0 + S && cyc <= stop_c;
      e_stim  = in_meas && ((cyc - t0 - S) % 2 == 1);
      e_stop  = in_meas && (cyc == stop_c || abort);
      e_valid = live && res_c >= 0 && cyc >= res_c && xfer_c < 0;
      chk("busy", 64'(busy), 64'(m_active));
      chk("fin_test", 64'(fin_test), 64'(e_fin));
      chk("start_tick", 64'(start_tick), 64'(e_start));
      chk("stop_tick", 64'(stop_tick), 64'(e_stop));
      chk("stim_out", 64'(stim_out), 64'(e_stim));
      chk("result_valid", 64'(result_valid), 64'(e_valid));
      chk("capa_code", 64'(capa_charge_code), 64'(m_code));
      if (e_valid) begin
        chk("result_capa", 64'(result_capa), 64'(m_res_capa));
        chk("result_energy", 64'(result_energy), 64'(m_energy));
        chk("result_timeout", 64'(result_timeout), 64'(m_to));
      end
      if (start_tick) start_cyc.push_back(cyc);
      if (stop_tick) stop_cyc.push_back(cyc);
      if (fin_test) n_fin++;
      if (stim_out) n_stim_hi++;
      if (result_valid && !prev_valid) vrise.push_back(cyc);
      if (result_valid && result_ready && !abort) begin
        xfer_capa.push_back(int'(result_capa));
        xfer_to.push_back(int'(result_timeout));
        xfer_en.push_back(result_energy);
      end
    end
    prev_valid = result_valid;
  end

  // Background driver: energy responder, result_ready and abort.
  initial begin
    int pend;
    pend = 0;
    forever begin
      @(negedge clk);
      if (rst_n && stop_tick && resp_dly > 0)
        pend = resp_rand ? int'($urandom_range(1, 80)) : resp_dly;
      @(posedge clk);
      #2;
      energy_in    = $urandom;
      energy_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) energy_valid = 1'b1;
      end else if (noise_en && $urandom_range(0, 9) == 0) begin
        energy_valid = 1'b1;
      end
      case (rdy_mode)
        0:       result_ready = 1'b1;
        1:       result_ready = 1'b0;
        default: result_ready = ($urandom_range(0, 2) != 0);
      endcase
      abort = abort_req || (abort_rnd && $urandom_range(0, 299) == 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_sweep(input int f, input int l, input int s, input bit with_abort);
    capa_first = 8'(f);
    capa_last  = 8'(l);
    capa_step  = 8'(s);
    go         = 1'b1;
    abort_req  = with_abort;
    tick();
    go        = 1'b0;
    abort_req = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string nm);
    int k = 0;
    while (busy && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: busy still 1 after %0d cycles, expected idle", nm, budget);
    end
    tick();
  endtask

  task automatic wait_start(input int budget, input string nm);
    int k = 0;
    while (!start_tick && k < budget) begin
      tick();
      k++;
    end
    if (k >= budget) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no start_tick within %0d cycles", nm, budget);
    end
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_capa"}, 64'(capa_charge_code), 64'd0);
    chk({nm, "_stim"}, 64'(stim_out), 64'd0);
    chk({nm, "_start"}, 64'(start_tick), 64'd0);
    chk({nm, "_stop"}, 64'(stop_tick), 64'd0);
    chk({nm, "_valid"}, 64'(result_valid), 64'd0);
    chk({nm, "_rcapa"}, 64'(result_capa), 64'd0);
    chk({nm, "_renergy"}, 64'(result_energy), 64'd0);
    chk({nm, "_rto"}, 64'(result_timeout), 64'd0);
    chk({nm, "_busy"}, 64'(busy), 64'd0);
    chk({nm, "_fin"}, 64'(fin_test), 64'd0);
  endtask

  initial begin
    int bx, bs, bp, bf, bh, bv, k;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst_n = 1'b1;
    repeat (5) tick();

    // Three points 2,4,6 with energy three cycles after each stop_tick.
    bx = xfer_capa.size(); bs = start_cyc.size(); bp = stop_cyc.size();
    bf = n_fin; bh = n_stim_hi;
    start_sweep(2, 6, 2, 1'b0);
    wait_idle(2000, "sweep3");
    chk("sweep3_nres", 64'(xfer_capa.size() - bx), 64'd3);
    chk("sweep3_nstart", 64'(start_cyc.size() - bs), 64'd3);
    chk("sweep3_nstop", 64'(stop_cyc.size() - bp), 64'd3);
    chk("sweep3_fin", 64'(n_fin - bf), 64'd1);
    chk("sweep3_stimhi", 64'(n_stim_hi - bh), 64'd24);
    for (int i = 0; i < 3; i++) begin
      if (bx + i < xfer_capa.size()) begin
        chk("sweep3_capa", 64'(xfer_capa[bx + i]), 64'(2 + 2 * i));
        chk("sweep3_to", 64'(xfer_to[bx + i]), 64'd0);
      end
      if (bs + i < start_cyc.size() && bp + i < stop_cyc.size())
        chk("sweep3_window", 64'(stop_cyc[bp + i] - start_cyc[bs + i]), 64'd16);
    end

    // No energy: timeout result 64 cycles after stop_tick.
    resp_dly = 0;
    bx = xfer_capa.size(); bp = stop_cyc.size(); bv = vrise.size();
    start_sweep(5, 5, 1, 1'b0);
    wait_idle(2000, "timeout");
    resp_dly = 3;
    chk("to_nres", 64'(xfer_capa.size() - bx), 64'd1);
    if (bx < xfer_capa.size()) begin
      chk("to_flag", 64'(xfer_to[bx]), 64'd1);
      chk("to_energy", 64'(xfer_en[bx]), 64'd0);
    end
    if (bv < vrise.size() && bp < stop_cyc.size())
      chk("to_delay", 64'(vrise[bv] - stop_cyc[bp]), 64'd64);

    // Near top of code range: no wrap.
    bx = xfer_capa.size(); bf = n_fin;
    start_sweep(250, 255, 10, 1'b0);
    wait_idle(2000, "nowrap");
    chk("nowrap_nres", 64'(xfer_capa.size() - bx), 64'd1);
    if (bx < xfer_capa.size()) chk("nowrap_capa", 64'(xfer_capa[bx]), 64'd250);
    chk("nowrap_fin", 64'(n_fin - bf), 64'd1);
    chk("nowrap_hold", 64'(capa_charge_code), 64'd250);

    // first > last gives one point; step 0 acts as step 1.
    bx = xfer_capa.size();
    start_sweep(9, 3, 4, 1'b0);
    wait_idle(2000, "rev");
    chk("rev_nres", 64'(xfer_capa.size() - bx), 64'd1);
    bx = xfer_capa.size();
    start_sweep(20, 22, 0, 1'b0);
    wait_idle(2000, "step0");
    chk("step0_nres", 64'(xfer_capa.size() - bx), 64'd3);
    if (bx + 2 < xfer_capa.size()) chk("step0_last", 64'(xfer_capa[bx + 2]), 64'd22);

    // Back-pressure: result held stable for 20 cycles.
    rdy_mode = 1;
    bx = xfer_capa.size();
    start_sweep(10, 10, 1, 1'b0);
    k = 0;
    while (!result_valid && k < 200) begin tick(); k++; end
    chk("bp_seen", 64'(result_valid), 64'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("bp_valid", 64'(result_valid), 64'd1);
      chk("bp_capa", 64'(result_capa), 64'd10);
      chk("bp_to", 64'(result_timeout), 64'd0);
    end
    chk("bp_noxfer", 64'(xfer_capa.size() - bx), 64'd0);
    rdy_mode = 0;
    wait_idle(2000, "bp");
    chk("bp_nres", 64'(xfer_capa.size() - bx), 64'd1);

    // Abort in the 5th measurement cycle.
    start_sweep(30, 40, 5, 1'b0);
    wait_start(100, "abort");
    repeat (5) tick();
    abort_req = 1'b1;
    @(negedge clk);
    chk("abort_stop", 64'(stop_tick), 64'd1);
    @(posedge clk); #1;
    abort_req = 1'b0;
    @(negedge clk);
    chk("abort_fin", 64'(fin_test), 64'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    repeat (5) tick();

    // Reset in the middle of a measurement window.
    start_sweep(40, 60, 3, 1'b0);
    wait_start(100, "rst");
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midrst");
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (5) tick();
    start_sweep(7, 9, 1, 1'b0);
    chk("rst_restart", 64'(capa_charge_code), 64'd7);
    wait_idle(2000, "rst");

    // Randomized sweeps with noise, random ready and random aborts.
    resp_rand = 1'b1; noise_en = 1'b1; abort_rnd = 1'b1; rdy_mode = 2;
    for (int n = 0; n < 14; n++) begin
      int f, l, s;
      f = int'($urandom_range(0, 255));
      s = int'($urandom_range(0, 12));
      l = (s < 2) ? f + int'($urandom_range(0, 3)) : f + int'($urandom_range(0, 30));
      if ($urandom_range(0, 4) == 0) l = f - 3;
      if (l > 255) l = 255;
      if (l < 0) l = 0;
      start_sweep(f, l, s, $urandom_range(0, 3) == 0);
      wait_idle(6000, "rand");
      repeat (int'($urandom_range(0, 4))) tick();
    end
    abort_rnd = 1'b0; noise_en = 1'b0;
    repeat (5) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    n_bad++;
    $display("FAIL watchdog: simulation did not finish in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule
